// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA burst planner
//
// Purpose: state and error encodings, burst request record, 4 KB boundary constant.
// Ports: none (package).
package dma_pkg;

    localparam int DMA_4KB = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } dma_bp_st_e;

    typedef enum logic [1:0] {
        NONE            = 2'd0,
        ADDR_OVF        = 2'd1,
        SPURIOUS_FINISH = 2'd2
    } dma_bp_err_e;

    // Widest-case burst record for consumers that want one bundle.
    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  alen;
        logic [2:0]  size;
        logic [11:0] head;
        logic [11:0] tail;
        logic        last;
    } s_dma_burst_req_t;

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - combinational burst split arithmetic
//
// Purpose: from current address A and remaining bytes R, compute the next legal
// INCR burst (limited by data end, MAX_BEATS and the next 4 KB boundary) and the
// A/R left after it.
// Ports:
//   cur_addr_i   A, one bit wider than the bus so A may equal 2^ADDR_WIDTH
//   rem_i        R
//   burst_addr_o beat-aligned burst start
//   alen_o       beats-1
//   head_o       leading bytes to drop in the first beat
//   tail_o       trailing bytes to drop in the last beat
//   last_o       no bytes remain after this burst
//   next_addr_o  A after this burst
//   next_rem_o   R after this burst
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int  DATA_WIDTH = 512,
    parameter int  ADDR_WIDTH = 32,
    parameter int  MAX_BEATS  = 256,
    localparam int OFFS_W     = $clog2(DATA_WIDTH / 8)
) (
    input  logic [ADDR_WIDTH:0]   cur_addr_i,
    input  logic [ADDR_WIDTH:0]   rem_i,
    output logic [ADDR_WIDTH-1:0] burst_addr_o,
    output logic [7:0]            alen_o,
    output logic [OFFS_W-1:0]     head_o,
    output logic [OFFS_W-1:0]     tail_o,
    output logic                  last_o,
    output logic [ADDR_WIDTH:0]   next_addr_o,
    output logic [ADDR_WIDTH:0]   next_rem_o
);

    localparam int BPB = DATA_WIDTH / 8;
    localparam int AW1 = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] need;
    logic [ADDR_WIDTH:0] to4k;
    logic [ADDR_WIDTH:0] beats;
    logic [ADDR_WIDTH:0] bytes;
    logic [OFFS_W-1:0]   end_lo;

    // head+R never exceeds 2^ADDR_WIDTH, so the rounded sum fits in AW1 bits.
    assign need   = (AW1'(head_o) + rem_i + AW1'(BPB - 1)) >> OFFS_W;
    assign to4k   = AW1'(DMA_4KB / BPB) - AW1'(cur_addr_i[11:OFFS_W]);
    // Only the byte lane of the data end matters for the tail.
    assign end_lo = cur_addr_i[OFFS_W-1:0] + rem_i[OFFS_W-1:0];

    always_comb begin
        beats = need;
        if (beats > AW1'(MAX_BEATS)) begin
            beats = AW1'(MAX_BEATS);
        end
        if (beats > to4k) begin
            beats = to4k;
        end
    end

    assign head_o       = cur_addr_i[OFFS_W-1:0];
    // A split burst always ends beat-aligned, so the tail only applies to the final piece.
    assign tail_o       = (beats == need) ? (OFFS_W'(0) - end_lo) : '0;
    assign bytes        = (beats << OFFS_W) - AW1'(head_o) - AW1'(tail_o);
    assign alen_o       = 8'(beats - AW1'(1));
    assign burst_addr_o = {cur_addr_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
    assign next_addr_o  = cur_addr_i + bytes;
    assign next_rem_o   = rem_i - bytes;
    assign last_o       = (next_rem_o == '0);

endmodule

// File: rtl/dma_burst_planner.sv
// rtl/dma_burst_planner.sv - descriptor to INCR burst request planner
//
// Purpose: splits one descriptor (byte address + byte count) into bursts legal
// for one AXI side, tracks outstanding bursts and pulses done_o when all finish.
// Optional: define DMA_BURST_PLANNER_PERF_EN to add perf_bursts_o / perf_stall_o.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   start_i, desc_addr_i,
//   desc_bytes_i                   descriptor in (ignored while busy_o)
//   busy_o, done_o                 descriptor in progress / complete pulse
//   err_o, err_src_o, err_addr_o   sticky error, source, address
//   req_valid_o, req_ready_i,
//   req_addr_o .. req_last_o       burst request handshake and fields
//   resp_finish_i                  one pulse per completed burst
module dma_burst_planner
    import dma_pkg::*;
#(
    parameter int  DATA_WIDTH      = 512,
    parameter int  ADDR_WIDTH      = 32,
    parameter int  MAX_BEATS       = 256,
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  STREAM_TYPE     = 0,
    localparam int OFFS_W          = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] desc_addr_i,
    input  logic [31:0]           desc_bytes_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_src_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [7:0]            req_alen_o,
    output logic [2:0]            req_size_o,
    output logic [OFFS_W-1:0]     req_head_o,
    output logic [OFFS_W-1:0]     req_tail_o,
    output logic                  req_last_o,
    input  logic                  resp_finish_i
`ifdef DMA_BURST_PLANNER_PERF_EN
    ,
    output logic [31:0]           perf_bursts_o,
    output logic [31:0]           perf_stall_o
`endif
);

    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int SW    = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    if (DATA_WIDTH < 16 || DATA_WIDTH > 8 * DMA_4KB || ADDR_WIDTH < 12 ||
        MAX_BEATS < 1 || MAX_BEATS > 256 || MAX_OUTSTANDING < 1 ||
        STREAM_TYPE < 0 || STREAM_TYPE > 1) begin : g_bad_params
        $error("dma_burst_planner: illegal parameter set");
    end

    dma_bp_st_e            state_q;
    dma_bp_err_e           err_src_q;
    logic [ADDR_WIDTH:0]   cur_a_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic [OUT_W-1:0]      outst_q;
    logic                  busy_q, done_q, err_q, req_valid_q, req_last_q;
    logic [ADDR_WIDTH-1:0] err_addr_q, req_addr_q;
    logic [7:0]            req_alen_q;
    logic [2:0]            req_size_q;
    logic [OFFS_W-1:0]     req_head_q, req_tail_q;

    logic [ADDR_WIDTH-1:0] c_addr;
    logic [7:0]            c_alen;
    logic [OFFS_W-1:0]     c_head, c_tail;
    logic                  c_last;
    logic [ADDR_WIDTH:0]   c_next_a, c_next_r;

    logic                  hs;
    logic                  credit_ok;
    logic                  desc_ovf;
    logic [SW-1:0]         desc_end;

    dma_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_calc (
        .cur_addr_i   (cur_a_q),
        .rem_i        (rem_q),
        .burst_addr_o (c_addr),
        .alen_o       (c_alen),
        .head_o       (c_head),
        .tail_o       (c_tail),
        .last_o       (c_last),
        .next_addr_o  (c_next_a),
        .next_rem_o   (c_next_r)
    );

    assign hs        = req_valid_q & req_ready_i;
    assign credit_ok = (outst_q < OUT_W'(MAX_OUTSTANDING));
    // Ending exactly at 2^ADDR_WIDTH is legal; one byte beyond is not.
    assign desc_end  = SW'(desc_addr_i) + SW'(desc_bytes_i);
    assign desc_ovf  = (desc_end > (SW'(1) << ADDR_WIDTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            err_src_q   <= NONE;
            cur_a_q     <= '0;
            rem_q       <= '0;
            outst_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_alen_q  <= '0;
            req_size_q  <= '0;
            req_head_q  <= '0;
            req_tail_q  <= '0;
            req_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q      <= 1'b0;
                        err_src_q  <= NONE;
                        err_addr_q <= '0;
                        cur_a_q    <= AW1'(desc_addr_i);
                        rem_q      <= AW1'(desc_bytes_i);
                        if (desc_bytes_i == 32'd0) begin
                            done_q <= 1'b1;
                        end else if (desc_ovf) begin
                            err_q      <= 1'b1;
                            err_src_q  <= ADDR_OVF;
                            err_addr_q <= desc_addr_i;
                            done_q     <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (credit_ok) begin
                        req_valid_q <= 1'b1;
                        req_addr_q  <= c_addr;
                        req_alen_q  <= c_alen;
                        req_size_q  <= 3'(OFFS_W);
                        req_head_q  <= c_head;
                        req_tail_q  <= c_tail;
                        req_last_q  <= c_last;
                        cur_a_q     <= c_next_a;
                        rem_q       <= c_next_r;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // rem_q already holds what is left after the burst on offer.
                    if (req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (rem_q == '0) ? DRAIN : CALC;
                    end
                end
                DRAIN: begin
                    if (outst_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (hs && !resp_finish_i) begin
                outst_q <= outst_q + OUT_W'(1);
            end else if (!hs && resp_finish_i) begin
                if (outst_q != '0) begin
                    outst_q <= outst_q - OUT_W'(1);
                end else begin
                    err_q      <= 1'b1;
                    err_src_q  <= SPURIOUS_FINISH;
                    err_addr_q <= cur_a_q[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_src_o   = err_src_q;
    assign err_addr_o  = err_addr_q;
    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign req_alen_o  = req_alen_q;
    assign req_size_o  = req_size_q;
    assign req_head_o  = req_head_q;
    assign req_tail_o  = req_tail_q;
    assign req_last_o  = req_last_q;

`ifdef DMA_BURST_PLANNER_PERF_EN
    logic [31:0] perf_bursts_q, perf_stall_q;
    logic        stall_evt;

    assign stall_evt = (req_valid_q & ~req_ready_i) | ((state_q == CALC) & ~credit_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_bursts_q <= '0;
            perf_stall_q  <= '0;
        end else if (start_i && state_q == IDLE) begin
            perf_bursts_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (hs && perf_bursts_q != '1) begin
                perf_bursts_q <= perf_bursts_q + 32'd1;
            end
            if (stall_evt && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_bursts_o = perf_bursts_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule
